fetch_sequencer: RTL

- Instruction-fetch and PC-sequencing stage directly upstream of the main decoder.
- Owns the PC and the instruction register (IR).
- Fetches from instruction memory over a req/ack handshake and presents op/funct/instr to the decoder.
- Computes the next PC from the decoder's branch/ne/jump/jr/link outputs plus ALU zero, and advances only when the datapath finishes executing the held instruction.

---
 rtl/fetch_sequencer_pkg.sv | 31 +++
 rtl/fetch_sequencer_if.sv | 21 ++
 rtl/fetch_sequencer_next_pc_logic.sv | 36 +++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch / PC-sequencing stage.
package fetch_pkg;

    // state | meaning
    // IDLE  | one-cycle settle after reset, then fetch
    // FETCH | imem_req high, waiting for imem_ack
    // EXEC  | IR valid, waiting for the datapath to finish
    // HALT  | trapped, frozen until reset
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [1:0] TRAP_NONE     = 2'b00;
    localparam logic [1:0] TRAP_MISALIGN = 2'b01;
    localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int JIDX_MSB  = 25;
    localparam int IMM_MSB   = 15;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_logic.sv
// Next-PC target computation with priority jr > jump > branch-taken > pc+4.
import fetch_pkg::*;

module next_pc_logic (
    input  logic [31:0]       pc,
    input  logic [JIDX_MSB:0] target_field,
    input  logic [31:0]       rs_val,
    input  logic              branch,
    input  logic              ne,
    input  logic              jump,
    input  logic              jr,
    input  logic              zero,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       next_pc
);
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        taken;

    assign pc_plus4      = pc + 32'd4;
    assign jump_target   = {pc_plus4[31:28], target_field, 2'b00};
    assign branch_target = pc_plus4 + branch_offset(target_field[IMM_MSB:0]);
    // ne inverts the sense of zero so one compare serves both beq and bne
    assign taken         = branch & (zero ^ ne);

    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
            next_pc = rs_val;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage: owns PC and IR, fetches over the imem handshake, sequences the PC.
import fetch_pkg::*;

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    fetch_sequencer_if.master   imem,
    output logic [31:0]         instr,
    output logic [5:0]          op,
    output logic [5:0]          funct,
    output logic                instr_valid,
    input  logic                branch,
    input  logic                ne,
    input  logic                jump,
    input  logic                jr,
    input  logic                link,
    input  logic                zero,
    input  logic [31:0]         rs_val,
    input  logic                exec_stall,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                trap,
    output logic [1:0]          trap_cause
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t        state;
    logic          req_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   next_pc;
    logic          unused_link;

    // link only steers the register write elsewhere; pc_plus4 is the value it needs
    assign unused_link    = link;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign op             = instr[OP_MSB:OP_LSB];
    assign funct          = instr[FUNCT_MSB:FUNCT_LSB];

    next_pc_logic u_next_pc (
        .pc           (pc),
        .target_field (instr[JIDX_MSB:0]),
        .rs_val       (rs_val),
        .branch       (branch),
        .ne           (ne),
        .jump         (jump),
        .jr           (jr),
        .zero         (zero),
        .pc_plus4     (pc_plus4),
        .next_pc      (next_pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            req_q       <= 1'b0;
            trap        <= 1'b0;
            trap_cause  <= TRAP_NONE;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_q <= 1'b1;
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem.imem_ack) begin
                        instr       <= imem.imem_rdata;
                        instr_valid <= 1'b1;
                        wait_cnt    <= '0;
                        req_q       <= 1'b0;
                        state       <= EXEC;
                    end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
                        // this cycle is the MAX_WAIT-th without an ack
                        wait_cnt <= wait_cnt + CW'(1);
                        trap     <= 1'b1;
                        if (trap_cause == TRAP_NONE) begin
                            trap_cause <= TRAP_TIMEOUT;
                        end
                        req_q <= 1'b0;
                        state <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                EXEC: begin
                    if (!exec_stall) begin
                        instr_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            trap <= 1'b1;
                            if (trap_cause == TRAP_NONE) begin
                                trap_cause <= TRAP_MISALIGN;
                            end
                            req_q <= 1'b0;
                            state <= HALT;
                        end else begin
                            pc    <= next_pc;
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    req_q       <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    req_q <= 1'b0;
                    state <= HALT;
                end
            endcase
        end
    end
endmodule
